// File: rtl/xalu_ise_pipe.sv
// Xoodyak ISE ALU (roli/andn/xorrol) as an elastic pipeline; XALU_ISE_PERF_EN adds retire counters.
// Latency: LAT cycles from accept to retire, strictly in order, one result per cycle.
// Backpressure: ise_ordy low freezes the output stage; upstream stages fill, then ise_rdy drops.
module xalu_ise_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter logic [1:0]  ISE_V = 2'b11,
    parameter int unsigned LAT   = 1
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic [4:0]      ise_fn,
    input  logic [6:0]      ise_imm,
    input  logic [XLEN-1:0] ise_in1,
    input  logic [XLEN-1:0] ise_in2,
    input  logic            ise_val,
    output logic            ise_rdy,
    output logic            ise_oval,
    input  logic            ise_ordy,
    output logic [XLEN-1:0] ise_out,
    output logic            ise_ill
`ifdef XALU_ISE_PERF_EN
    ,
    output logic [31:0]     ise_cnt,
    output logic [15:0]     ise_icnt
`endif
);

    localparam int unsigned SH = $clog2(XLEN);
    localparam int unsigned NL = XLEN / 32;

    // Only the custom-space bits take part in decode.
    logic unused_fn_hi;
    assign unused_fn_hi = ^ise_fn[4:2];

    logic            is_roli;
    logic            is_andn;
    logic            is_xorrol;
    logic [SH-1:0]   rot_amt;
    logic [XLEN-1:0] roli_res;
    logic [XLEN-1:0] andn_res;
    logic [XLEN-1:0] xorrol_res;
    logic [XLEN-1:0] s1_dat;
    logic            s1_ill;

    assign rot_amt   = ise_imm[SH-1:0];
    assign is_roli   = (ise_fn[1:0] == 2'b00) && ((ise_imm >> SH) == 7'd0) && ISE_V[0];
    assign is_andn   = (ise_fn[1:0] == 2'b01) && (ise_imm == 7'b0000000) && ISE_V[0];
    assign is_xorrol = (ise_fn[1:0] == 2'b01) && (ise_imm == 7'b0100000) && ISE_V[1];

    // A zero rotate shifts the right term out entirely, leaving rs1 unchanged.
    assign roli_res = (ise_in1 << rot_amt) | (ise_in1 >> (XLEN - rot_amt));
    assign andn_res = ise_in1 & ~ise_in2;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        logic [31:0] a;
        assign a = ise_in1[32*l +: 32];
        assign xorrol_res[32*l +: 32] = {a[26:0], a[31:27]} ^ {a[17:0], a[31:18]}
                                      ^ ise_in2[32*l +: 32];
    end

    always_comb begin
        s1_dat = '0;
        s1_ill = 1'b1;
        if (is_roli) begin
            s1_dat = roli_res;
            s1_ill = 1'b0;
        end else if (is_andn) begin
            s1_dat = andn_res;
            s1_ill = 1'b0;
        end else if (is_xorrol) begin
            s1_dat = xorrol_res;
            s1_ill = 1'b0;
        end
    end

    logic [LAT:1]    v_q;
    logic [LAT:1]    ill_q;
    logic [LAT:1]    ld;
    logic [XLEN-1:0] d_q [1:LAT];

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        ld      = '0;
        ld[LAT] = ~v_q[LAT] | ise_ordy;
        for (int k = int'(LAT) - 1; k >= 1; k--) begin
            ld[k] = ~v_q[k] | ld[k+1];
        end
    end

    // Empty stages always hold zero data and a clear ill flag, so plain copies
    // between stages keep the idle output at zero.
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            v_q   <= '0;
            ill_q <= '0;
            for (int k = 1; k <= int'(LAT); k++) begin
                d_q[k] <= '0;
            end
        end else begin
            if (ld[1]) begin
                v_q[1]   <= ise_val;
                ill_q[1] <= ise_val & s1_ill;
                d_q[1]   <= ise_val ? s1_dat : '0;
            end
            for (int k = 2; k <= int'(LAT); k++) begin
                if (ld[k]) begin
                    v_q[k]   <= v_q[k-1];
                    ill_q[k] <= ill_q[k-1];
                    d_q[k]   <= d_q[k-1];
                end
            end
        end
    end

    assign ise_rdy  = ld[1];
    assign ise_oval = v_q[LAT];
    assign ise_out  = d_q[LAT];
    assign ise_ill  = ill_q[LAT];

`ifdef XALU_ISE_PERF_EN
    logic retire;
    assign retire = v_q[LAT] & ise_ordy;

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            ise_cnt  <= '0;
            ise_icnt <= '0;
        end else if (retire) begin
            ise_cnt <= ise_cnt + 32'd1;
            if (ill_q[LAT] && (ise_icnt != 16'hFFFF)) begin
                ise_icnt <= ise_icnt + 16'd1;
            end
        end
    end
`endif

endmodule
